// File: rtl/elevator_call_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_call_scheduler
//
// Collects per-floor call pulses into a pending-call register and chooses
// the next target floor with a SCAN (elevator sweep) policy. The chosen
// target goes to the car controller over a valid/ready handshake. The
// scheduler then waits for the car to arrive and times the door dwell at
// every served floor.
//
// Optional feature macro: DOOR_HOLD_EN
//   defined   -> adds input door_hold. While it is high in SERVICE, the door
//                dwell keeps reloading, so the door stays open.
//   undefined -> no door_hold port. The dwell is a fixed DOOR_CYCLES.
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous, active-low reset
//   call_req      in   one bit per floor, level sampled every edge
//   car_floor     in   current car floor from the car controller
//   car_arrived   in   1-cycle pulse: car has stopped at car_floor
//   target_ready  in   car controller accepts target_floor
//   door_hold     in   (DOOR_HOLD_EN only) keep the door open
//   target_valid  out  target_floor is valid and held stable
//   target_floor  out  floor to travel to
//   pending       out  registered outstanding calls
//   door_open     out  high during the service dwell
//   direction     out  00 idle, 01 up, 10 down
//   busy          out  high in any state other than IDLE
// ---------------------------------------------------------------------------
module elevator_call_scheduler #(
    parameter int NUM_FLOORS  = 4,
    parameter int FLOOR_W     = 2,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    car_floor,
    input  logic                  car_arrived,
    input  logic                  target_ready,
`ifdef DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic                  target_valid,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic [1:0]            direction,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        MOVING,
        SERVICE
    } state_t;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    // A 1-cycle dwell still needs a one-bit counter.
    localparam int                 DWELL_W    = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DOOR_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

    state_t                state;
    state_t                state_next;
    logic [DWELL_W-1:0]    dwell;
    logic [DWELL_W-1:0]    dwell_nxt;
    logic [NUM_FLOORS-1:0] pending_nxt;
    logic                  target_valid_nxt;
    logic [FLOOR_W-1:0]    target_floor_nxt;
    logic                  door_open_nxt;
    logic [1:0]            direction_nxt;

    logic [NUM_FLOORS-1:0] car_onehot;
    logic                  at_car_floor;
    logic                  arrived_at_target;
    logic                  hold_active;
    logic                  up_found;
    logic                  dn_found;
    logic [FLOOR_W-1:0]    up_floor;
    logic [FLOOR_W-1:0]    dn_floor;
    logic [FLOOR_W-1:0]    scan_pick;

`ifdef DOOR_HOLD_EN
    assign hold_active = door_hold;
`else
    assign hold_active = 1'b0;
`endif

    assign car_onehot        = NUM_FLOORS'(1) << car_floor;
    assign at_car_floor      = |(pending & car_onehot);
    assign arrived_at_target = car_arrived && (car_floor == target_floor);
    assign busy              = (state != IDLE);

    // SCAN pick. Find the nearest pending floor strictly above and strictly
    // below the car. Keep sweeping in the current direction when possible,
    // otherwise reverse. An idle car prefers to go up. The car's own floor
    // is never pending here, because IDLE serves it in place.
    always_comb begin
        up_found = 1'b0;
        dn_found = 1'b0;
        up_floor = '0;
        dn_floor = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(car_floor))) begin
                up_found = 1'b1;
                up_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(car_floor))) begin
                dn_found = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end
        if (direction == DIR_DOWN) begin
            scan_pick = dn_found ? dn_floor : up_floor;
        end else begin
            scan_pick = up_found ? up_floor : dn_floor;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. SERVICE leaves only once the dwell has expired and
    // nobody is holding the door.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_next = at_car_floor ? SERVICE : DISPATCH;
                end
            end
            DISPATCH: begin
                if (target_ready) begin
                    state_next = MOVING;
                end
            end
            MOVING: begin
                if (arrived_at_target) begin
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (!hold_active && (dwell == '0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output and datapath next values. The current floor is masked out of
    // the pending calls on the edge that enters SERVICE, so a clear wins
    // over a same-edge call. It stays masked while the door is open.
    // Direction is left untouched in SERVICE so the sweep continues.
    always_comb begin
        pending_nxt = pending | call_req;
        if ((state_next == SERVICE) || (state == SERVICE)) begin
            pending_nxt = pending_nxt & ~car_onehot;
        end
        target_valid_nxt = target_valid;
        target_floor_nxt = target_floor;
        door_open_nxt    = door_open;
        direction_nxt    = direction;
        dwell_nxt        = dwell;
        case (state)
            IDLE: begin
                if (pending == '0) begin
                    direction_nxt = DIR_IDLE;
                end else if (at_car_floor) begin
                    door_open_nxt = 1'b1;
                    dwell_nxt     = DWELL_LOAD;
                end else begin
                    target_floor_nxt = scan_pick;
                    target_valid_nxt = 1'b1;
                    direction_nxt    = (scan_pick > car_floor) ? DIR_UP : DIR_DOWN;
                end
            end
            DISPATCH: begin
                if (target_ready) begin
                    target_valid_nxt = 1'b0;
                end
            end
            MOVING: begin
                if (arrived_at_target) begin
                    door_open_nxt = 1'b1;
                    dwell_nxt     = DWELL_LOAD;
                end
            end
            SERVICE: begin
                if (hold_active) begin
                    dwell_nxt = DWELL_LOAD;
                end else if (dwell == '0) begin
                    door_open_nxt = 1'b0;
                end else begin
                    dwell_nxt = dwell - DWELL_ONE;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers. Reset drops any handshake or dwell
    // that is in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= '0;
            target_valid <= 1'b0;
            target_floor <= '0;
            door_open    <= 1'b0;
            direction    <= DIR_IDLE;
            dwell        <= '0;
        end else begin
            pending      <= pending_nxt;
            target_valid <= target_valid_nxt;
            target_floor <= target_floor_nxt;
            door_open    <= door_open_nxt;
            direction    <= direction_nxt;
            dwell        <= dwell_nxt;
        end
    end

endmodule
